debug_reg_writer: RTL and testbench
===================================

DEBUG_REG_WRITER -- requirements
Module: debug_reg_writer

Interface
REQ-001 Parameters: DEPTH, default 4, number of queue entries (power of 2, at least 2); STARVE, default 8, wait-cycle threshold that raises stall_req.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port dbg_wr_valid, input, 1 bit: debug write request.
REQ-005 Port dbg_wr_ready, output, 1 bit: request accepted when valid and ready are both high at a rising edge.
REQ-006 Port dbg_wr_addr, input, 5 bits: target register index.
REQ-007 Port dbg_wr_data, input, 32 bits: write data.
REQ-008 Port wb_we, input, 1 bit: pipeline writeback enable.
REQ-009 Port wb_addr, input, 5 bits: pipeline writeback register index.
REQ-010 Port wb_data, input, 32 bits: pipeline writeback data.
REQ-011 Port rf_we, output, 1 bit: register-file write enable.
REQ-012 Port rf_addr, output, 5 bits: register-file write index.
REQ-013 Port rf_data, output, 32 bits: register-file write data.
REQ-014 Port stall_req, output, 1 bit: request to freeze the pipeline so a debug write can drain.
REQ-015 Port busy, output, 1 bit: queue not empty.
REQ-016 Port dbg_wr_cnt, output, 16 bits: saturating count of debug writes committed to the register file.

Function
REQ-017 Debug requests shall be buffered in a FIFO of DEPTH entries, each holding {addr, data}, in strict arrival order.
REQ-018 dbg_wr_ready shall equal "FIFO not full", derived from registered state only, with no combinational path from any input.
REQ-019 When the FIFO is full, dbg_wr_ready shall be 0 even if a pop occurs in the same cycle; there is no push-through when full.
REQ-020 An accepted request with dbg_wr_addr == 0 shall be consumed and discarded: nothing is enqueued and dbg_wr_cnt does not change.
REQ-021 There is no bypass: an entry pushed at edge N is eligible to drive rf_we no earlier than the cycle after edge N.
REQ-022 "wb active" is defined as wb_we == 1 and wb_addr != 0.
REQ-023 When wb is active, the rf_* outputs shall carry wb_we/wb_addr/wb_data combinationally and the FIFO head shall be held.
REQ-024 When wb is not active and the FIFO is non-empty, rf_we = 1, rf_addr/rf_data = the FIFO head, and the head is popped at the next edge.
REQ-025 When wb is not active and the FIFO is empty, rf_we = 0, rf_addr = 0, rf_data = 0.
REQ-026 A simultaneous push and pop in the same cycle shall leave the occupancy unchanged; the read and write pointers wrap modulo DEPTH.
REQ-027 Wait counter: cleared when the FIFO is empty or on a pop; otherwise incremented each cycle the head is blocked by wb; saturates at STARVE.
REQ-028 stall_req shall be 1 exactly while the wait counter == STARVE; it is registered state, deasserted at the edge that pops the head.
REQ-029 dbg_wr_cnt shall increment by 1 at each pop and hold at 16'hFFFF.
REQ-030 busy = (occupancy != 0), registered.
REQ-031 A debug write and a wb write to the same index are not merged; the later rf write wins, in commit order.

Reset
REQ-032 While rst_n == 0, regardless of clk, the block shall clear both pointers, occupancy, wait counter, stall_req, busy and dbg_wr_cnt.
REQ-033 At reset, dbg_wr_ready shall be 1 and rf_* shall follow REQ-023/REQ-025 (all zero with wb idle).
REQ-034 Reset asserted mid-operation shall discard all queued entries; no rf_we pulse for those entries shall occur after rst_n rises.

Verification
REQ-035 Scenario, single write: wb idle, push {addr 5, data 0xDEADBEEF} -> the next cycle shows rf_we = 1, rf_addr = 5, rf_data = 0xDEADBEEF; then busy = 0 and dbg_wr_cnt = 1.
REQ-036 Scenario, fill: wb held active, push 5 requests back-to-back -> 4 accepted; dbg_wr_ready = 0 on the 5th until a pop; drained order matches push order.
REQ-037 Scenario, starvation: wb active continuously with 1 entry queued -> stall_req = 1 after 8 blocked cycles; wb deasserted -> entry committed; stall_req = 0 the next cycle.
REQ-038 Scenario, x0: push addr 0, data 0x1234 -> accepted; no rf_we; busy stays 0; dbg_wr_cnt unchanged.
REQ-039 Scenario, async reset: with 3 entries queued, rst_n pulsed low between edges -> outputs clear immediately; no debug rf_we afterwards; dbg_wr_ready = 1.
REQ-040 Scenario, concurrent push/pop: FIFO at 2 entries, wb idle, one push per cycle for 10 cycles -> occupancy stays 2; pointers wrap; dbg_wr_cnt = 10.

Source files
------------

// File: rtl/debug_reg_writer.sv
// Debug register-file writer.
// Queues debug write requests in a small FIFO and merges them into the
// register-file write port. The pipeline writeback always has priority.
// A head entry that is blocked for too long raises stall_req so the
// pipeline can be frozen long enough for the entry to drain.
module debug_reg_writer #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbg_wr_valid,
  output logic        dbg_wr_ready,
  input  logic [4:0]  dbg_wr_addr,
  input  logic [31:0] dbg_wr_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        stall_req,
  output logic        busy,
  output logic [15:0] dbg_wr_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = $clog2(STARVE + 1);
  localparam logic [AW:0]   LP_FULL   = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] LP_STARVE = WW'(STARVE);

  logic [36:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [WW-1:0] r_wait;
  logic          r_stall;
  logic          r_busy;
  logic [15:0]   r_cnt;

  logic          w_wb_active;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [36:0]   w_head;
  logic [AW:0]   w_count_nxt;
  logic [WW-1:0] w_wait_nxt;

  // Ready is a pure function of registered occupancy: no push-through when full.
  assign dbg_wr_ready = (r_count != LP_FULL);
  assign w_wb_active  = wb_we && (wb_addr != 5'd0);
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rptr];
  // Writes to x0 are accepted but dropped here, never enqueued.
  assign w_push       = dbg_wr_valid && dbg_wr_ready && (dbg_wr_addr != 5'd0);
  assign w_pop        = !w_wb_active && !w_empty;

  assign stall_req  = r_stall;
  assign busy       = r_busy;
  assign dbg_wr_cnt = r_cnt;

  // Register-file port mux: writeback first, then FIFO head, else idle zeros.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 32'd0;
    if (w_wb_active) begin
      rf_we   = wb_we;
      rf_addr = wb_addr;
      rf_data = wb_data;
    end else if (!w_empty) begin
      rf_we   = 1'b1;
      rf_addr = w_head[36:32];
      rf_data = w_head[31:0];
    end
  end

  // Next occupancy and next wait-counter value.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - 1'b1;

    w_wait_nxt = r_wait;
    if (w_empty || w_pop)
      w_wait_nxt = '0;
    else if (w_wb_active && (r_wait != LP_STARVE))
      w_wait_nxt = r_wait + 1'b1;
  end

  // Control state: pointers, occupancy, starvation tracking, status, counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wait  <= '0;
      r_stall <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= 16'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_wait  <= w_wait_nxt;
      r_stall <= (w_wait_nxt == LP_STARVE);
      r_busy  <= (w_count_nxt != '0);
      if (w_pop && (r_cnt != 16'hFFFF))
        r_cnt <= r_cnt + 16'd1;
    end
  end

  // FIFO storage: data only, no reset needed since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {dbg_wr_addr, dbg_wr_data};
  end

endmodule

// File: tb/tb_debug_reg_writer.sv
// Testbench for debug_reg_writer: randomized and directed scenarios checked
// against a queue-based reference model.
module tb_debug_reg_writer;

  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dbg_wr_valid = 1'b0;
  logic        dbg_wr_ready;
  logic [4:0]  dbg_wr_addr = 5'd0;
  logic [31:0] dbg_wr_data = 32'd0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall_req;
  logic        busy;
  logic [15:0] dbg_wr_cnt;

  int checks = 0;
  int errors = 0;

  logic [56:0] dut_out;
  logic [56:0] exp_out;
  assign dut_out = {dbg_wr_ready, rf_we, rf_addr, rf_data, stall_req, busy, dbg_wr_cnt};

  debug_reg_writer #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(dbg_wr_ready),
    .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .stall_req(stall_req), .busy(busy), .dbg_wr_cnt(dbg_wr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  // Reference model: pending debug writes as a queue of {addr, data}.
  logic [36:0] mq[$];
  int          m_wait;
  logic [15:0] m_cnt;

  task automatic model_reset();
    mq.delete();
    m_wait = 0;
    m_cnt  = 16'd0;
  endtask

  // Advance the model by one rising edge using the currently applied inputs.
  task automatic model_step();
    bit wb_act, pop, push;
    int sz;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sz     = mq.size();
    wb_act = wb_we && (wb_addr != 5'd0);
    pop    = !wb_act && (sz > 0);
    push   = dbg_wr_valid && (sz < DEPTH) && (dbg_wr_addr != 5'd0);
    if (sz == 0 || pop) m_wait = 0;
    else if (wb_act && m_wait < STARVE) m_wait = m_wait + 1;
    if (pop) begin
      void'(mq.pop_front());
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    if (push) mq.push_back({dbg_wr_addr, dbg_wr_data});
  endtask

  function automatic logic [56:0] model_out();
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [36:0] h;
    we = 1'b0; a = 5'd0; d = 32'd0;
    if (wb_we && wb_addr != 5'd0) begin
      we = 1'b1; a = wb_addr; d = wb_data;
    end else if (mq.size() > 0) begin
      h = mq[0]; we = 1'b1; a = h[36:32]; d = h[31:0];
    end
    return {(mq.size() < DEPTH), we, a, d, (m_wait >= STARVE), (mq.size() != 0), m_cnt};
  endfunction

  task automatic set_in(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
    dbg_wr_valid = v; dbg_wr_addr = a; dbg_wr_data = d;
    wb_we = we; wb_addr = wa; wb_data = wd;
  endtask

  // Reset pulse between edges; returns aligned just after a rising edge.
  task automatic do_reset();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); model_step(); #1;
  endtask

  task automatic test_reset();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    model_reset();
    #3;
    exp_out = model_out();
    checks++;
    if (dut_out !== exp_out) begin
      errors++; $display("FAIL reset_initial got %h exp %h", dut_out, exp_out);
    end
    @(posedge clk); @(negedge clk);
    exp_out = model_out();
    checks++;
    if (dut_out !== exp_out) begin
      errors++; $display("FAIL reset_held got %h exp %h", dut_out, exp_out);
    end
    rst_n = 1'b1;
    @(posedge clk); model_step(); #1;
  endtask

  task automatic test_single_write();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      else        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk); exp_out = model_out();
      checks++;
      if (dut_out !== exp_out) begin
        errors++; $display("FAIL single_write cyc%0d got %h exp %h", i, dut_out, exp_out);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_x0();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_in(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
      else        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk); exp_out = model_out();
      checks++;
      if (dut_out !== exp_out) begin
        errors++; $display("FAIL x0_write cyc%0d got %h exp %h", i, dut_out, exp_out);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_fill();
    logic [31:0] d5;
    d5 = $urandom;
    for (int i = 0; i < 16; i++) begin
      // cycles 0-7 wb active; 0-4 fresh pushes, 5-8 keep the rejected 5th pending
      if (i < 5)      set_in(1'b1, 5'(1 + $urandom % 31), (i == 4) ? d5 : $urandom,
                             1'b1, 5'(1 + $urandom % 31), $urandom);
      else if (i < 8) set_in(1'b1, dbg_wr_addr, d5, 1'b1, 5'(1 + $urandom % 31), $urandom);
      else if (i < 10) set_in(1'b1, dbg_wr_addr, d5, 1'b0, 5'd0, 32'd0);
      else            set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk); exp_out = model_out();
      checks++;
      if (dut_out !== exp_out) begin
        errors++; $display("FAIL fill cyc%0d got %h exp %h", i, dut_out, exp_out);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_starve();
    for (int i = 0; i < 15; i++) begin
      if (i == 0)      set_in(1'b1, 5'd9, $urandom, 1'b1, 5'd3, $urandom);
      else if (i < 11) set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'(1 + $urandom % 31), $urandom);
      else             set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'(1 + $urandom % 31), $urandom);
      @(negedge clk); exp_out = model_out();
      checks++;
      if (dut_out !== exp_out) begin
        errors++; $display("FAIL starve cyc%0d got %h exp %h", i, dut_out, exp_out);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_concurrent();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i < 2)       set_in(1'b1, 5'(1 + $urandom % 31), $urandom, 1'b1, 5'd7, $urandom);
      else if (i < 12) set_in(1'b1, 5'(1 + $urandom % 31), $urandom, 1'b0, 5'd0, 32'd0);
      else             set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk); exp_out = model_out();
      checks++;
      if (dut_out !== exp_out) begin
        errors++; $display("FAIL concurrent cyc%0d got %h exp %h", i, dut_out, exp_out);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'(1 + $urandom % 31), $urandom, 1'b1, 5'd4, $urandom);
      @(posedge clk); model_step(); #1;
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hA5A5A5A5);
    @(negedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    exp_out = model_out();
    checks++;
    if (dut_out !== exp_out) begin
      errors++; $display("FAIL async_reset_now got %h exp %h", dut_out, exp_out);
    end
    #1 rst_n = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); model_step(); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); exp_out = model_out();
      checks++;
      if (dut_out !== exp_out) begin
        errors++; $display("FAIL async_reset_after cyc%0d got %h exp %h", i, dut_out, exp_out);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 3) != 0, (($urandom % 6) == 0) ? 5'd0 : 5'($urandom),
             $urandom, ($urandom % 5) < 2, 5'($urandom), $urandom);
      @(negedge clk); exp_out = model_out();
      checks++;
      if (dut_out !== exp_out) begin
        errors++; $display("FAIL random cyc%0d got %h exp %h", i, dut_out, exp_out);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_cnt_saturate();
    do_reset();
    for (int i = 0; i < 65545; i++) begin
      set_in(1'b1, 5'(1 + $urandom % 31), $urandom, 1'b0, 5'd0, 32'd0);
      if (i >= 65530) begin
        @(negedge clk); exp_out = model_out();
        checks++;
        if (dut_out !== exp_out) begin
          errors++; $display("FAIL cnt_saturate cyc%0d got %h exp %h", i, dut_out, exp_out);
        end
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_x0();
    test_fill();
    test_starve();
    test_concurrent();
    test_async_reset();
    test_random();
    test_cnt_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
